// File: rtl/alu_pkg.sv
// Shared constants for the 32-bit execute-stage ALU: data width and opcode map.
package alu_pkg;
    localparam int ALU_W = 32;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_ADCS = 4'b0001;
    localparam logic [3:0] OP_ANDS = 4'b0010;
    localparam logic [3:0] OP_ORRS = 4'b0011;
    localparam logic [3:0] OP_RSBS = 4'b0100;
    localparam logic [3:0] OP_SBCS = 4'b0101;
    localparam logic [3:0] OP_SUBS = 4'b0110;
    localparam logic [3:0] OP_CMP  = 4'b0111;
    localparam logic [3:0] OP_MULS = 4'b1000;
endpackage

// File: rtl/alu_addsub.sv
// 33-bit adder shared by every add/subtract opcode; subtraction is done by the
// caller inverting one operand and supplying the carry-in.
module alu_addsub
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] x,
    input  logic [ALU_W-1:0] y,
    input  logic             ci,
    output logic [ALU_W-1:0] sum,
    output logic             co
);
    logic [ALU_W:0] total;

    assign total = {1'b0, x} + {1'b0, y} + {{ALU_W{1'b0}}, ci};
    assign sum   = total[ALU_W-1:0];
    assign co    = total[ALU_W];
endmodule

// File: rtl/alu32.sv
// Single-cycle-latency 32-bit ALU with registered result and flags.
// Define ALU_MUL_EN to build the MULS opcode; otherwise 1000 acts as undefined.
module alu32
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ALU_W-1:0]  a,
    input  logic [ALU_W-1:0]  b,
    input  logic              cin,
    input  logic [3:0]        opcode,
    output logic [ALU_W-1:0]  result,
    output logic              cout,
    output logic              NegativeFlag,
    output logic              ZeroFlag
);
    logic [ALU_W-1:0] add_x;
    logic [ALU_W-1:0] add_y;
    logic             add_ci;
    logic [ALU_W-1:0] add_sum;
    logic             add_co;

    logic [ALU_W-1:0] value_next;
    logic             cout_next;
    logic             hold_result;

    logic [ALU_W-1:0] result_reg;
    logic             cout_reg;
    logic             nf_reg;
    logic             zf_reg;

    // Steer operands so one adder covers add, reverse-subtract and subtract.
    always_comb begin
        add_x  = a;
        add_y  = ~b;
        add_ci = 1'b1;
        case (opcode)
            OP_ADD: begin
                add_y  = b;
                add_ci = 1'b0;
            end
            OP_ADCS: begin
                add_y  = b;
                add_ci = cin;
            end
            OP_RSBS: begin
                add_x  = b;
                add_y  = ~a;
            end
            OP_SBCS: add_ci = cin;
            default: ;
        endcase
    end

    alu_addsub u_addsub (
        .x   (add_x),
        .y   (add_y),
        .ci  (add_ci),
        .sum (add_sum),
        .co  (add_co)
    );

`ifdef ALU_MUL_EN
    logic [ALU_W-1:0] mul_lo;
    assign mul_lo = a * b;
`endif

    always_comb begin
        value_next  = '0;
        cout_next   = 1'b0;
        hold_result = 1'b0;
        case (opcode)
            OP_ADD, OP_ADCS, OP_RSBS, OP_SBCS, OP_SUBS: begin
                value_next = add_sum;
                cout_next  = add_co;
            end
            OP_CMP: begin
                value_next  = add_sum;
                cout_next   = add_co;
                hold_result = 1'b1;
            end
            OP_ANDS: value_next = a & b;
            OP_ORRS: value_next = a | b;
`ifdef ALU_MUL_EN
            OP_MULS: value_next = mul_lo;
`endif
            default: ;
        endcase
    end

    // Flags come from the operation value, so CMP reports the difference it
    // computed even though the visible result is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_reg <= '0;
            cout_reg   <= 1'b0;
            nf_reg     <= 1'b0;
            zf_reg     <= 1'b1;
        end else begin
            if (!hold_result) begin
                result_reg <= value_next;
            end
            cout_reg <= cout_next;
            nf_reg   <= value_next[ALU_W-1];
            zf_reg   <= (value_next == '0);
        end
    end

    assign result       = result_reg;
    assign cout         = cout_reg;
    assign NegativeFlag = nf_reg;
    assign ZeroFlag     = zf_reg;
endmodule

// File: tb/tb_alu32.sv
// Directed-vector bench for alu32 with hand-computed expectations; honours ALU_MUL_EN.
module tb_alu32;
    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [3:0]  opcode;
    logic [31:0] result;
    logic        cout;
    logic        NegativeFlag;
    logic        ZeroFlag;

    int checks = 0;
    int errors = 0;

    alu32 dut (
        .clk          (clk),
        .rst          (rst),
        .a            (a),
        .b            (b),
        .cin          (cin),
        .opcode       (opcode),
        .result       (result),
        .cout         (cout),
        .NegativeFlag (NegativeFlag),
        .ZeroFlag     (ZeroFlag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] er, input logic ec,
                             input logic en, input logic ez);
        check({tag, ".result"}, result, er);
        check({tag, ".cout"}, {31'b0, cout}, {31'b0, ec});
        check({tag, ".nf"}, {31'b0, NegativeFlag}, {31'b0, en});
        check({tag, ".zf"}, {31'b0, ZeroFlag}, {31'b0, ez});
    endtask

    // Called just after a rising edge: apply inputs, clock once, sample #1 later.
    task automatic run(input string tag, input logic [3:0] op, input logic [31:0] va,
                       input logic [31:0] vb, input logic vc, input logic [31:0] er,
                       input logic ec, input logic en, input logic ez);
        opcode = op;
        a      = va;
        b      = vb;
        cin    = vc;
        @(posedge clk);
        #1;
        $display("op=%b a=%08h b=%08h cin=%0d -> result=%08h cout=%0d nf=%0d zf=%0d (%s)",
                 op, va, vb, vc, result, cout, NegativeFlag, ZeroFlag, tag);
        check_all(tag, er, ec, en, ez);
    endtask

    initial begin
        rst    = 1'b1;
        opcode = 4'b0000;
        a      = 32'd15;
        b      = 32'd10;
        cin    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("reset held 2 cycles -> result=%08h cout=%0d nf=%0d zf=%0d",
                 result, cout, NegativeFlag, ZeroFlag);
        check_all("reset", 32'd0, 1'b0, 1'b0, 1'b1);

        rst = 1'b0;
        @(posedge clk);
        #1;
        $display("release reset -> result=%08h", result);
        check("post_reset_add", result, 32'd25);

        run("add",        4'b0000, 32'd15, 32'd10, 1'b0, 32'd25, 1'b0, 1'b0, 1'b0);
        run("adcs",       4'b0001, 32'd15, 32'd10, 1'b1, 32'd26, 1'b0, 1'b0, 1'b0);
        run("add_wrap",   4'b0000, 32'hFFFFFFFF, 32'd1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
        run("adcs_wrap",  4'b0001, 32'hFFFFFFFF, 32'd0, 1'b1, 32'd0, 1'b1, 1'b0, 1'b1);
        run("ands",       4'b0010, 32'd12, 32'd5, 1'b0, 32'd4, 1'b0, 1'b0, 1'b0);
        run("orrs",       4'b0011, 32'd12, 32'd5, 1'b1, 32'd13, 1'b0, 1'b0, 1'b0);
        run("rsbs",       4'b0100, 32'd10, 32'd15, 1'b0, 32'd5, 1'b1, 1'b0, 1'b0);
        run("sbcs_c1",    4'b0101, 32'd20, 32'd5, 1'b1, 32'd15, 1'b1, 1'b0, 1'b0);
        run("sbcs_c0",    4'b0101, 32'd20, 32'd5, 1'b0, 32'd14, 1'b1, 1'b0, 1'b0);
        run("subs",       4'b0110, 32'd20, 32'd5, 1'b0, 32'd15, 1'b1, 1'b0, 1'b0);
        run("subs_neg",   4'b0110, 32'd5, 32'd20, 1'b0, 32'hFFFFFFF1, 1'b0, 1'b1, 1'b0);
        run("preload",    4'b0110, 32'd20, 32'd5, 1'b0, 32'd15, 1'b1, 1'b0, 1'b0);
        run("cmp_eq",     4'b0111, 32'd10, 32'd10, 1'b0, 32'd15, 1'b1, 1'b0, 1'b1);
        run("cmp_lt",     4'b0111, 32'd5, 32'd20, 1'b1, 32'd15, 1'b0, 1'b1, 1'b0);
`ifdef ALU_MUL_EN
        run("muls",       4'b1000, 32'd3, 32'd3, 1'b0, 32'd9, 1'b0, 1'b0, 1'b0);
`else
        run("muls_off",   4'b1000, 32'd3, 32'd3, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
`endif
        run("undef_f",    4'b1111, 32'd7, 32'd9, 1'b1, 32'd0, 1'b0, 1'b0, 1'b1);
        run("undef_9",    4'b1001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'd0, 1'b0, 1'b0, 1'b1);

        // Mid-stream reset discards the operation on its inputs.
        run("pre_rst",    4'b0000, 32'd1, 32'd2, 1'b0, 32'd3, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        run("mid_rst",    4'b0000, 32'd1, 32'd2, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        run("cmp_after_rst", 4'b0111, 32'd10, 32'd10, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
        run("add_after",  4'b0000, 32'h80000000, 32'd0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
